// File: rtl/k423_pipe_buf.sv
// In-order DEPTH-entry pipeline buffer with valid/ready on both sides, PCU clear and stall.
// The head payload is held in its own register, so dn_data_o never sees up_data_i combinationally.
module k423_pipe_buf #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 2,
  parameter int CLR_DATA = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clear_i,
  input  logic                       stall_i,
  input  logic                       up_vld_i,
  output logic                       up_rdy_o,
  input  logic [DATA_W-1:0]          up_data_i,
  output logic                       dn_vld_o,
  input  logic                       dn_rdy_i,
  output logic [DATA_W-1:0]          dn_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("k423_pipe_buf: DEPTH must be in 1..4");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dn_data_q, dn_data_d;
  logic              push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  if (DEPTH == 1) begin : g_single
    // Pass-through ready: a full single entry can be replaced while it is popped.
    assign up_rdy_o = ((count_q == '0) | dn_rdy_i) & ~stall_i;
  end else begin : g_multi
    logic alive_q, alive_d;
    assign alive_d = 1'b1;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) alive_q <= 1'b0;
      else          alive_q <= alive_d;
    end
    // Ready is held low until the first edge out of reset.
    assign up_rdy_o = alive_q & (count_q < FULL_CNT) & ~stall_i;
  end

  assign dn_vld_o  = (count_q != '0) & ~stall_i;
  assign dn_data_o = dn_data_q;
  assign count_o   = count_q;
  assign push      = up_vld_i & up_rdy_o;
  assign pop       = dn_vld_o & dn_rdy_i;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dn_data_d = dn_data_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (CLR_DATA != 0) begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        dn_data_d = '0;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = up_data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      // When the buffer drains, the output keeps the last popped payload.
      if (count_d != '0) dn_data_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dn_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dn_data_q <= dn_data_d;
    end
  end

endmodule

// File: tb/tb_k423_pipe_buf.sv
// Bench for k423_pipe_buf: three configurations share stimulus and are compared every cycle
// against a list-based behavioural model, plus literal expectations from the test plan.
module tb_k423_pipe_buf;

  localparam int NI = 3;
  localparam int DEPS [NI] = '{2, 3, 1};
  localparam int CLRS [NI] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, stall, up_vld;
  logic [63:0] up_data;
  logic        dn_rdy    [NI];
  logic        up_rdy_a  [NI];
  logic        dn_vld_a  [NI];
  logic [63:0] dd_all    [NI];
  logic [31:0] cnt_all   [NI];

  int checks = 0;
  int errors = 0;

  // Model: each instance is a plain ordered list (index 0 = oldest).
  logic [63:0] m  [NI][4];
  int          sz [NI];
  logic [63:0] ld [NI];
  bit          alive [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CW = $clog2(DEPS[gi] + 1);
    logic [CW-1:0] cnt;
    logic [63:0]   dd;
    k423_pipe_buf #(.DATA_W(64), .DEPTH(DEPS[gi]), .CLR_DATA(CLRS[gi])) u_dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .clear_i   (clear),
      .stall_i   (stall),
      .up_vld_i  (up_vld),
      .up_rdy_o  (up_rdy_a[gi]),
      .up_data_i (up_data),
      .dn_vld_o  (dn_vld_a[gi]),
      .dn_rdy_i  (dn_rdy[gi]),
      .dn_data_o (dd),
      .count_o   (cnt)
    );
    assign cnt_all[gi] = 32'(cnt);
    assign dd_all[gi]  = dd;
  end

  function automatic logic e_vld(int k);
    return (sz[k] != 0) && !stall;
  endfunction

  function automatic logic e_rdy(int k);
    if (DEPS[k] == 1) return ((sz[k] == 0) || dn_rdy[k]) && !stall;
    return alive[k] && (sz[k] < DEPS[k]) && !stall;
  endfunction

  function automatic logic [63:0] e_data(int k);
    return (sz[k] != 0) ? m[k][0] : ld[k];
  endfunction

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk("up_rdy",  k, 64'(up_rdy_a[k]), 64'(e_rdy(k)));
      chk("dn_vld",  k, 64'(dn_vld_a[k]), 64'(e_vld(k)));
      chk("dn_data", k, dd_all[k], e_data(k));
      chk("count",   k, 64'(cnt_all[k]), 64'(sz[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      sz[k] = 0; ld[k] = '0; alive[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      logic        push, pop;
      logic [63:0] hd;
      push = up_vld && e_rdy(k);
      pop  = e_vld(k) && dn_rdy[k];
      hd   = e_data(k);
      if (clear) begin
        sz[k] = 0;
        ld[k] = (CLRS[k] != 0) ? 64'd0 : hd;
      end else begin
        if (pop) begin
          ld[k] = m[k][0];
          for (int i = 0; i < 3; i++) m[k][i] = m[k][i+1];
          sz[k]--;
        end
        if (push) begin
          m[k][sz[k]] = up_data;
          sz[k]++;
        end
      end
      alive[k] = 1'b1;
    end
  endtask

  // Inputs are driven at the falling edge; outputs are compared 1 time unit later.
  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic set_rdy(logic v);
    for (int k = 0; k < NI; k++) dn_rdy[k] = v;
  endtask

  task automatic idle(int n);
    up_vld = 1'b0; clear = 1'b0; stall = 1'b0; set_rdy(1'b1);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push_n(int n, logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      up_vld = 1'b1; up_data = base + 64'(i);
      cyc();
    end
    up_vld = 1'b0;
  endtask

  initial begin
    logic [63:0] vals [3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    rst_n = 1'b0; clear = 1'b0; stall = 1'b0; up_vld = 1'b0; up_data = '0;
    set_rdy(1'b0);
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Streaming on DEPTH=2: one beat per cycle, count holds at 1.
    for (int i = 0; i < 3; i++) begin
      up_vld = 1'b1; up_data = vals[i];
      cyc();
      chk("stream_data", 0, dd_all[0], vals[i]);
      chk("stream_cnt",  0, 64'(cnt_all[0]), 64'd1);
    end
    idle(4);

    // Backpressure on DEPTH=3, then drain with pointer wrap.
    set_rdy(1'b0);
    push_n(4, 64'hA0);
    up_vld = 1'b1;
    #1;
    chk("fill_cnt",  1, 64'(cnt_all[1]), 64'd3);
    chk("fill_rdy",  1, 64'(up_rdy_a[1]), 64'd0);
    chk("fill_head", 1, dd_all[1], 64'hA0);
    up_vld = 1'b0;
    set_rdy(1'b1);
    push_n(5, 64'hF0);
    idle(6);

    // DEPTH=1 full throughput: held entry replaced every beat.
    set_rdy(1'b0);
    push_n(1, 64'hBF);
    set_rdy(1'b1);
    for (int i = 0; i < 8; i++) begin
      up_vld = 1'b1; up_data = 64'hB0 + 64'(i);
      #1;
      chk("d1_rdy", 2, 64'(up_rdy_a[2]), 64'd1);
      cyc();
      chk("d1_cnt",  2, 64'(cnt_all[2]), 64'd1);
      chk("d1_data", 2, dd_all[2], 64'hB0 + 64'(i));
    end
    idle(5);

    // Stall freezes a two-entry DEPTH=2 buffer.
    set_rdy(1'b0);
    push_n(2, 64'hC1);
    stall = 1'b1; up_vld = 1'b1; up_data = 64'hCC; set_rdy(1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_vld",  0, 64'(dn_vld_a[0]), 64'd0);
      chk("stall_rdy",  0, 64'(up_rdy_a[0]), 64'd0);
      chk("stall_cnt",  0, 64'(cnt_all[0]), 64'd2);
      chk("stall_data", 0, dd_all[0], 64'hC1);
    end
    stall = 1'b0; up_vld = 1'b0;
    #1;
    chk("resume_vld",  0, 64'(dn_vld_a[0]), 64'd1);
    chk("resume_data", 0, dd_all[0], 64'hC1);
    idle(5);

    // Clear beats stall and push; CLR_DATA decides what dn_data shows afterwards.
    set_rdy(1'b0);
    push_n(2, 64'hD1);
    clear = 1'b1; stall = 1'b1; up_vld = 1'b1; up_data = 64'hEE;
    cyc();
    clear = 1'b0; stall = 1'b0; up_vld = 1'b0;
    #1;
    chk("clr_cnt",  0, 64'(cnt_all[0]), 64'd0);
    chk("clr_vld",  0, 64'(dn_vld_a[0]), 64'd0);
    chk("clr_data", 0, dd_all[0], 64'd0);
    chk("clr_cnt",  1, 64'(cnt_all[1]), 64'd0);
    chk("clr_hold", 1, dd_all[1], 64'hD1);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      stall   = ($urandom_range(7) == 0);
      clear   = ($urandom_range(31) == 0);
      up_vld  = $urandom_range(3) != 0;
      up_data = {$urandom, $urandom};
      for (int k = 0; k < NI; k++) dn_rdy[k] = $urandom_range(2) != 0;
      cyc();
    end

    // Asynchronous reset between edges with two entries held.
    idle(1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    set_rdy(1'b0);
    push_n(2, 64'hE1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_cnt",  0, 64'(cnt_all[0]), 64'd0);
    chk("arst_vld",  0, 64'(dn_vld_a[0]), 64'd0);
    chk("arst_data", 0, dd_all[0], 64'd0);
    check_all();
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 40; i++) begin
      up_vld  = $urandom_range(1) != 0;
      up_data = {$urandom, $urandom};
      for (int k = 0; k < NI; k++) dn_rdy[k] = $urandom_range(1) != 0;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
